width_12to8: RTL and testbench

- 12-bit to 8-bit non-integer width converter; the return path paired with the team's 8-to-12 packer.
- Accepts 12-bit words from an upstream valid/ready source and emits a contiguous MSB-first byte stream.
- Every two input words (24 bits) produce three output bytes.
- Sits between a 12-bit datapath stage and an 8-bit byte sink that has no backpressure.

---
 rtl/width_conv_pkg.sv | 24 ++
 rtl/width_12to8.sv | 74 +++++++
 tb/tb_width_12to8.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/width_conv_pkg.sv
// Shared widths and counter constants for the 12<->8 bit width converters.
package width_conv_pkg;

  localparam int IN_W  = 12;
  localparam int OUT_W = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 5;

  // Largest post-emit fill level that still leaves room for a whole input word.
  localparam logic [CNT_W-1:0] CNT_READY_MAX = 5'd8;
  // Bit-count steps for one emitted byte and one accepted word.
  localparam logic [CNT_W-1:0] CNT_OUT_STEP  = 5'd8;
  localparam logic [CNT_W-1:0] CNT_IN_STEP   = 5'd12;

  // Place a word MSB-first directly behind 'pos' already-buffered bits of a
  // left-aligned accumulator.
  function automatic logic [ACC_W-1:0] align_word(input logic [IN_W-1:0]  word,
                                                  input logic [CNT_W-1:0] pos);
    logic [ACC_W-1:0] left;
    left = {word, {(ACC_W-IN_W){1'b0}}};
    return left >> pos;
  endfunction

endpackage

// File: rtl/width_12to8.sv
// 12-bit to 8-bit width converter: two accepted words become three MSB-first
// bytes. The byte sink has no backpressure, so a byte leaves whenever at
// least 8 bits are buffered.
module width_12to8
  import width_conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out
);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid_out;
  logic [OUT_W-1:0] r_data_out;

  logic             w_out_fire;
  logic             w_in_fire;
  logic [CNT_W-1:0] w_cnt_post;
  logic [CNT_W-1:0] w_cnt_next;
  logic [ACC_W-1:0] w_acc_shift;
  logic [ACC_W-1:0] w_acc_next;

  // Next-state: emit a byte first (shift out), then append any accepted word
  // directly behind the bits that remain.
  always_comb begin
    w_out_fire = (r_cnt >= CNT_OUT_STEP);
    if (w_out_fire) begin
      w_cnt_post  = r_cnt - CNT_OUT_STEP;
      w_acc_shift = {r_acc[ACC_W-OUT_W-1:0], {OUT_W{1'b0}}};
    end else begin
      w_cnt_post  = r_cnt;
      w_acc_shift = r_acc;
    end

    ready_in  = rst_n && (w_cnt_post <= CNT_READY_MAX);
    w_in_fire = valid_in && ready_in;

    if (w_in_fire) begin
      w_acc_next = w_acc_shift | align_word(data_in, w_cnt_post);
      w_cnt_next = w_cnt_post + CNT_IN_STEP;
    end else begin
      w_acc_next = w_acc_shift;
      w_cnt_next = w_cnt_post;
    end
  end

  // Accumulator, fill count and registered byte output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_valid_out <= 1'b0;
      r_data_out  <= {OUT_W{1'b0}};
    end else begin
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_valid_out <= w_out_fire;
      if (w_out_fire) begin
        r_data_out <= r_acc[ACC_W-1 -: OUT_W];
      end else begin
        r_data_out <= r_data_out;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_width_12to8.sv
// Bench for width_12to8: directed scenarios plus a randomized stream, checked
// against a bit-queue serialization model.
module tb_width_12to8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  data_out;

  int errors = 0;
  int checks = 0;

  // Reference model: every accepted bit, MSB first, not yet emitted.
  bit         mq[$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       last_ready;
  logic [7:0] seen[$];

  width_12to8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Room for a word exists when, after one byte leaves, at most 8 bits remain.
  function automatic logic model_ready();
    int n;
    n = mq.size();
    if (n >= 8) n = n - 8;
    return (n <= 8);
  endfunction

  // One clock cycle: drive at the falling edge, check ready, advance the model
  // at the rising edge, check outputs just after it.
  task automatic step(input logic v, input logic [11:0] d, output logic fired);
    logic       r;
    logic [7:0] b;
    valid_in = v;
    data_in  = d;
    #1;
    r = model_ready();
    last_ready = ready_in;
    chk("ready_in", ready_in, r);
    fired = v && r;
    @(posedge clk);
    if (mq.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], mq.pop_front()};
      exp_valid = 1'b1;
      exp_data  = b;
    end else begin
      exp_valid = 1'b0;
    end
    if (fired) for (int i = 11; i >= 0; i--) mq.push_back(d[i]);
    #1;
    chk("valid_out", valid_out, exp_valid);
    chk("data_out", data_out, exp_data);
    if (valid_out === 1'b1) seen.push_back(data_out);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, f);
  endtask

  logic       f;
  int         idx;
  int         accepted;
  logic [11:0] w;
  logic       v;
  logic       exp_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] exp_cont[9] = '{8'h00, 8'h10, 8'h02, 8'h00, 8'h30, 8'h04, 8'h00, 8'h50, 8'h06};
  logic [7:0] exp_pair[3] = '{8'hAB, 8'hCD, 8'hEF};
  logic [7:0] exp_bp  [6] = '{8'h11, 8'h12, 8'h22, 8'h33, 8'h31, 8'h23};

  initial begin
    // Power-up reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_ready_in", ready_in, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready_in", ready_in, 1'b1);
    @(negedge clk);

    // Single pair ABC, DEF
    seen.delete();
    step(1'b1, 12'hABC, f);
    chk("pair_first_latency", valid_out, 1'b0);
    step(1'b1, 12'hDEF, f);
    chk("pair_first_byte_valid", valid_out, 1'b1);
    chk("pair_first_byte", data_out, 8'hAB);
    idle(3);
    chk("pair_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("pair_byte", seen[i], exp_pair[i]);

    // Continuous stream 001..006 with valid held high
    seen.delete();
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 12'(idx + 1), f);
      chk("cont_ready_pattern", last_ready, exp_rdy[s]);
      if (f) idx++;
    end
    chk("cont_words_accepted", idx, 6);
    idle(3);
    chk("cont_count", seen.size(), 9);
    for (int i = 0; i < 9 && i < seen.size(); i++) chk("cont_byte", seen[i], exp_cont[i]);

    // Odd word count: residue held until the next word
    seen.delete();
    step(1'b1, 12'h5A3, f);
    idle(5);
    chk("odd_count", seen.size(), 1);
    if (seen.size() > 0) chk("odd_byte", seen[0], 8'h5A);
    chk("odd_ready_held", ready_in, 1'b1);
    seen.delete();
    step(1'b1, 12'h7E1, f);
    idle(3);
    chk("odd_tail_count", seen.size(), 2);
    if (seen.size() > 1) begin
      chk("odd_tail_b0", seen[0], 8'h37);
      chk("odd_tail_b1", seen[1], 8'hE1);
    end

    // Backpressure: word presented while full must be held, not lost/duplicated
    seen.delete();
    step(1'b1, 12'h111, f);
    step(1'b1, 12'h222, f);
    step(1'b1, 12'h333, f);
    step(1'b1, 12'h123, f);
    chk("bp_ready_low", last_ready, 1'b0);
    for (int i = 0; i < 4 && !f; i++) step(1'b1, 12'h123, f);
    chk("bp_accepted", f, 1'b1);
    idle(4);
    chk("bp_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("bp_byte", seen[i], exp_bp[i]);

    // Reset mid-stream with 16 bits buffered
    step(1'b1, 12'hA5A, f);
    step(1'b1, 12'h5A5, f);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_valid_out", valid_out, 1'b0);
    chk("mid_rst_data_out", data_out, 8'h00);
    chk("mid_rst_ready_in", ready_in, 1'b0);
    mq.delete();
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release_ready", ready_in, 1'b1);
    @(negedge clk);
    idle(2);
    step(1'b1, 12'hB0B, f);
    step(1'b1, 12'h0B0, f);
    idle(3);

    // Randomized stream with idle gaps
    accepted = 0;
    w = 12'($urandom);
    for (int c = 0; c < 8000 && accepted < 1000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, v ? w : 12'($urandom), f);
      if (f) begin
        accepted++;
        w = 12'($urandom);
      end
    end
    chk("random_words_accepted", accepted, 1000);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
